input_buffer: RTL and testbench

INPUT_BUFFER -- requirements
Module: input_buffer

---
 rtl/noc_pkg.sv | 43 ++++
 rtl/flit_fifo.sv | 66 ++++++
 rtl/input_buffer.sv | 70 +++++++
 tb/tb_input_buffer.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions: port directions, grant codes and flit field positions.
// Used by the input buffer and by the output arbiters.
package noc_pkg;

    localparam int NUM_PORTS = 5;

    localparam int DIR_N = 0;
    localparam int DIR_S = 1;
    localparam int DIR_E = 2;
    localparam int DIR_W = 3;
    localparam int DIR_L = 4;

    localparam int DEST_Y_LSB = 0;
    localparam int DEST_Y_MSB = 1;
    localparam int DEST_X_LSB = 2;
    localparam int DEST_X_MSB = 3;

    typedef enum logic [2:0] {
        GNT_N       = 3'b000,
        GNT_S       = 3'b001,
        GNT_E       = 3'b010,
        GNT_W       = 3'b011,
        GNT_L       = 3'b100,
        GNT_INVALID = 3'b111
    } grant_e;

    typedef logic [NUM_PORTS-1:0] req_t;

    function automatic req_t grant_to_req(input grant_e g);
        req_t r;
        r = '0;
        case (g)
            GNT_N:   r[DIR_N] = 1'b1;
            GNT_S:   r[DIR_S] = 1'b1;
            GNT_E:   r[DIR_E] = 1'b1;
            GNT_W:   r[DIR_W] = 1'b1;
            GNT_L:   r[DIR_L] = 1'b1;
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/flit_fifo.sv
// Flit storage with a registered head word.
// The head register is zero whenever the FIFO is empty.
module flit_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push_req,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop_req,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_q;
    logic [AW-1:0]    rd_q;
    logic [AW-1:0]    rd_n;
    logic [CW-1:0]    rem;
    logic [CW-1:0]    cnt_n;
    logic             push;
    logic             pop_v;
    logic [WIDTH-1:0] head_n;

    assign full  = (count == FULL_CNT);
    assign push  = push_req && !full;
    assign pop_v = pop_req && (count != '0);
    assign rd_n  = rd_q + AW'(pop_v);
    assign rem   = count - CW'(pop_v);
    assign cnt_n = rem + CW'(push);

    // When nothing survives the pop, the incoming flit becomes the new head.
    always_comb begin
        head_n = '0;
        if (cnt_n != '0) begin
            head_n = (rem == '0) ? wdata : mem[rd_n];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_q] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            count <= '0;
            head  <= '0;
        end else begin
            wr_q  <= wr_q + AW'(push);
            rd_q  <= rd_n;
            count <= cnt_n;
            head  <= head_n;
        end
    end

endmodule

// File: rtl/input_buffer.sv
// Router input port: XY route computed on arrival, stored beside the flit.
// Head flit and its one-hot request come straight from registers.
module input_buffer
    import noc_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int CUR_X  = 0,
    parameter int CUR_Y  = 0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    in_valid,
    input  logic [DATA_W-1:0]       in_data,
    output logic                    in_ready,
    output logic [4:0]              out_req,
    output logic [DATA_W-1:0]       out_data,
    input  logic                    pop,
    output logic [$clog2(DEPTH):0]  count
);

    localparam logic [1:0] CX = 2'(CUR_X);
    localparam logic [1:0] CY = 2'(CUR_Y);
    localparam int HW = DATA_W + NUM_PORTS;

    logic [1:0]    dest_x;
    logic [1:0]    dest_y;
    grant_e        route_g;
    req_t          route_req;
    logic          full;
    logic [HW-1:0] head;

    assign dest_x = in_data[DEST_X_MSB:DEST_X_LSB];
    assign dest_y = in_data[DEST_Y_MSB:DEST_Y_LSB];

    // X is resolved before Y.
    always_comb begin
        route_g = GNT_L;
        if (dest_x > CX) begin
            route_g = GNT_E;
        end else if (dest_x < CX) begin
            route_g = GNT_W;
        end else if (dest_y > CY) begin
            route_g = GNT_N;
        end else if (dest_y < CY) begin
            route_g = GNT_S;
        end
    end

    assign route_req = grant_to_req(route_g);
    assign in_ready  = !full;

    flit_fifo #(
        .WIDTH (HW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push_req (in_valid),
        .wdata    ({route_req, in_data}),
        .pop_req  (pop),
        .head     (head),
        .count    (count),
        .full     (full)
    );

    assign out_req  = head[DATA_W +: NUM_PORTS];
    assign out_data = head[DATA_W-1:0];

endmodule

// File: tb/tb_input_buffer.sv
// Self-checking bench for input_buffer at router (1,1), depth 4.
// A queue-based reference model tracks the expected contents.
module tb_input_buffer;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic [4:0]  out_req;
    logic [31:0] out_data;
    logic        pop;
    logic [2:0]  count;

    int checks;
    int errors;
    logic [31:0] q[$];

    input_buffer #(
        .DATA_W (32),
        .DEPTH  (4),
        .CUR_X  (1),
        .CUR_Y  (1)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_req  (out_req),
        .out_data (out_data),
        .pop      (pop),
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] route_of(input logic [31:0] f);
        int dx;
        int dy;
        dx = int'(f[3:2]);
        dy = int'(f[1:0]);
        if (dx > 1) return 5'b00100;
        if (dx < 1) return 5'b01000;
        if (dy > 1) return 5'b00001;
        if (dy < 1) return 5'b00010;
        return 5'b10000;
    endfunction

    task automatic check_model(input string tag);
        int n;
        n = q.size();
        chk({tag, "_cnt"}, 64'(count), 64'(n));
        chk({tag, "_rdy"}, 64'(in_ready), 64'(n != 4));
        chk({tag, "_req"}, 64'(out_req),
            64'((n != 0) ? route_of(q[0]) : 5'b0));
        chk({tag, "_dat"}, 64'(out_data),
            64'((n != 0) ? q[0] : 32'h0));
    endtask

    task automatic cyc(input logic v, input logic [31:0] d, input logic p,
                       input string tag);
        int n;
        in_valid = v;
        in_data  = d;
        pop      = p;
        @(posedge clk);
        n = q.size();
        if (p && n != 0) void'(q.pop_front());
        if (v && n != 4) q.push_back(d);
        @(negedge clk);
        in_valid = 1'b0;
        pop      = 1'b0;
        check_model(tag);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        in_valid = 1'b0;
        in_data  = '0;
        pop      = 1'b0;
        reset_n  = 1'b0;
        #1;
        chk("rst_cnt", 64'(count), 64'd0);
        chk("rst_req", 64'(out_req), 64'd0);
        chk("rst_dat", 64'(out_data), 64'd0);
        chk("rst_rdy", 64'(in_ready), 64'd1);
        @(negedge clk);
        reset_n = 1'b1;

        // Eastbound flit appears one cycle after the push.
        cyc(1'b1, 32'hA5A5_000D, 1'b0, "east");
        chk("east_req", 64'(out_req), 64'b00100);
        chk("east_cnt", 64'(count), 64'd1);
        chk("east_dat", 64'(out_data), 64'hA5A5_000D);
        cyc(1'b0, '0, 1'b1, "east_pop");

        // L, N, W, S in order.
        cyc(1'b1, 32'h0000_0105, 1'b0, "seq_p0");
        cyc(1'b1, 32'h0000_0207, 1'b0, "seq_p1");
        cyc(1'b1, 32'h0000_0301, 1'b0, "seq_p2");
        cyc(1'b1, 32'h0000_0404, 1'b0, "seq_p3");
        chk("seq_r0", 64'(out_req), 64'b10000);
        cyc(1'b0, '0, 1'b1, "seq_q0");
        chk("seq_r1", 64'(out_req), 64'b00001);
        cyc(1'b0, '0, 1'b1, "seq_q1");
        chk("seq_r2", 64'(out_req), 64'b01000);
        cyc(1'b0, '0, 1'b1, "seq_q2");
        chk("seq_r3", 64'(out_req), 64'b00010);
        cyc(1'b0, '0, 1'b1, "seq_q3");
        chk("seq_end", 64'(out_req), 64'd0);

        // Fill past capacity, then pop with valid held while full.
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 32'h1000_0000 + 32'(i * 16 + 5), 1'b0, "fill");
        end
        chk("full_cnt", 64'(count), 64'd4);
        chk("full_rdy", 64'(in_ready), 64'd0);
        chk("full_dat", 64'(out_data), 64'h1000_0005);
        cyc(1'b1, 32'hDEAD_0005, 1'b1, "full_pp");
        chk("full_pp_cnt", 64'(count), 64'd3);
        chk("full_pp_dat", 64'(out_data), 64'h1000_0015);

        // Drain to two, then push and pop together.
        cyc(1'b0, '0, 1'b1, "dr");
        chk("two_cnt", 64'(count), 64'd2);
        cyc(1'b1, 32'h2222_000E, 1'b1, "two_pp");
        chk("two_pp_cnt", 64'(count), 64'd2);
        chk("two_pp_dat", 64'(out_data), 64'h1000_0035);
        cyc(1'b0, '0, 1'b1, "two_d0");
        chk("two_last", 64'(out_data), 64'h2222_000E);
        cyc(1'b0, '0, 1'b1, "two_d1");

        // Pops while empty are ignored.
        for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1, "epop");
        chk("epop_cnt", 64'(count), 64'd0);
        chk("epop_req", 64'(out_req), 64'd0);
        cyc(1'b1, 32'h3333_0009, 1'b1, "epush");
        chk("epush_dat", 64'(out_data), 64'h3333_0009);
        chk("epush_req", 64'(out_req), 64'b00100);
        cyc(1'b0, '0, 1'b1, "epush_pop");

        // Reset in the middle of a cycle with three flits stored.
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 32'h4444_0000 + 32'(i), 1'b0, "pre_rst");
        end
        #2;
        reset_n = 1'b0;
        #1;
        chk("mrst_req", 64'(out_req), 64'd0);
        chk("mrst_cnt", 64'(count), 64'd0);
        chk("mrst_dat", 64'(out_data), 64'd0);
        q.delete();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("post_rdy", 64'(in_ready), 64'd1);
        chk("post_req", 64'(out_req), 64'd0);
        @(negedge clk);
        check_model("post_idle");
        cyc(1'b1, 32'h5555_0006, 1'b0, "post_push");
        chk("post_dat", 64'(out_data), 64'h5555_0006);
        chk("post_cnt", 64'(count), 64'd1);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 9) < 6), $urandom,
                ($urandom_range(0, 9) < 5), "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
